// File: rtl/mem_pkg.sv
// Shared definitions for the backing-store controller and its L1 client:
// field widths, FSM state encoding and the byte-lane merge helper.
package mem_pkg;

    localparam int WORD_BITS   = 32;
    localparam int STROBE_BITS = 4;
    localparam int BYTE_BITS   = WORD_BITS / STROBE_BITS;
    localparam int ADDR_BITS   = 32;

    typedef logic [WORD_BITS-1:0]   word_t;
    typedef logic [STROBE_BITS-1:0] strobe_t;
    typedef logic [ADDR_BITS-1:0]   addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request fields captured at acceptance; the word index is held separately
    // because its width depends on the array depth.
    typedef struct packed {
        logic    write;
        word_t   data;
        strobe_t strobe;
    } mem_req_t;

    // Replace each byte lane of old_word whose strobe bit is set.
    function automatic word_t strobe_merge(
        input word_t   old_word,
        input word_t   new_word,
        input strobe_t strobe
    );
        word_t merged;
        merged = old_word;
        for (int b = 0; b < STROBE_BITS; b++) begin
            if (strobe[b]) begin
                merged[b*BYTE_BITS +: BYTE_BITS] = new_word[b*BYTE_BITS +: BYTE_BITS];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with per-byte write enables, read-first.
// Each byte lane is its own array so the lanes map onto byte-enable block RAM.
module mem_array
    import mem_pkg::*;
#(
    parameter int WORDS    = 256,
    localparam int IDX_BITS = $clog2(WORDS)
) (
    input  logic                i_clk,
    input  logic                i_en,
    input  logic [STROBE_BITS-1:0] i_we,
    input  logic [IDX_BITS-1:0] i_addr,
    input  logic [WORD_BITS-1:0] i_wdata,
    output logic [WORD_BITS-1:0] o_rdata
);

    generate
        for (genvar gi = 0; gi < STROBE_BITS; gi++) begin : g_lane
            logic [BYTE_BITS-1:0] r_lane [WORDS];
            logic [BYTE_BITS-1:0] r_lane_rdata;

            // Read-first: the read returns the word as it was before this edge's write.
            always_ff @(posedge i_clk) begin
                if (i_en) begin
                    r_lane_rdata <= r_lane[i_addr];
                    if (i_we[gi]) begin
                        r_lane[i_addr] <= i_wdata[gi*BYTE_BITS +: BYTE_BITS];
                    end
                end
            end

            assign o_rdata[gi*BYTE_BITS +: BYTE_BITS] = r_lane_rdata;
        end
    endgenerate

endmodule

// File: rtl/mem_controller.sv
// Fixed-latency request/response front end for the word-organised backing RAM.
// One request in flight; response appears exactly LATENCY edges after acceptance.
module mem_controller
    import mem_pkg::*;
#(
    parameter int WORDS   = 256,
    parameter int LATENCY = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_BITS-1:0]   req_address,
    input  logic [WORD_BITS-1:0]   req_data,
    input  logic [STROBE_BITS-1:0] req_strobe,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WORD_BITS-1:0]   resp_data,
    output logic                   busy
);

    localparam int IDX_BITS = $clog2(WORDS);
    localparam int CNT_BITS = $clog2(LATENCY) + 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_BITS-1:0]  r_count;
    mem_req_t             r_req;
    logic [IDX_BITS-1:0]  r_req_index;
    word_t                r_resp_data;

    logic                 w_req_ready;
    logic                 w_resp_valid;
    logic                 w_busy;
    logic                 w_accept;
    logic                 w_commit;
    logic [IDX_BITS-1:0]  w_index;
    logic                 w_ram_en;
    strobe_t              w_ram_we;
    logic [IDX_BITS-1:0]  w_ram_addr;
    word_t                w_rdata;
    word_t                w_merged;
    logic                 w_addr_unused;

    // Byte offset and bits above the array depth are deliberately dropped: addresses wrap.
    assign w_index       = req_address[IDX_BITS+1:2];
    assign w_addr_unused = ^{req_address[ADDR_BITS-1:IDX_BITS+2], req_address[1:0]};

    assign w_accept = req_valid && w_req_ready && !reset;
    assign w_commit = (r_state == WAIT) && (r_count == '0) && !reset;

    // The old word is fetched at acceptance so the merge is ready by the commit edge.
    assign w_ram_en   = w_accept || w_commit;
    assign w_ram_addr = w_commit ? r_req_index : w_index;
    assign w_ram_we   = (w_commit && r_req.write) ? r_req.strobe : '0;
    assign w_merged   = strobe_merge(w_rdata, r_req.data, r_req.strobe);

    mem_array #(
        .WORDS (WORDS)
    ) u_array (
        .i_clk   (clock),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_merged),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid)       w_state_next = WAIT;
            WAIT:    if (r_count == '0)   w_state_next = RESP;
            RESP:    if (resp_ready)      w_state_next = IDLE;
            default:                      w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_req_ready  = (r_state == IDLE);
        w_resp_valid = (r_state == RESP);
        w_busy       = (r_state != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count     <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) begin
                r_count <= CNT_LOAD;
            end else if ((r_state == WAIT) && (r_count != '0)) begin
                r_count <= r_count - CNT_ONE;
            end
            if (w_commit) begin
                r_resp_data <= r_req.write ? w_merged : w_rdata;
            end
        end
    end

    // Request fields are only looked at on the accept edge.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_req.write  <= req_write;
            r_req.data   <= req_data;
            r_req.strobe <= req_strobe;
            r_req_index  <= w_index;
        end
    end

    assign req_ready  = w_req_ready;
    assign resp_valid = w_resp_valid;
    assign resp_data  = r_resp_data;
    assign busy       = w_busy;

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: a LATENCY=4 and a LATENCY=1 instance,
// selected by sel1, sharing the request field drivers.
module tb_mem_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, resp_ready, sel1;
    logic [31:0] req_address, req_data;
    logic [3:0]  req_strobe;

    logic        ready4, valid4, busy4, ready1, valid1, busy1;
    logic [31:0] data4, data1;
    logic        v4, v1;
    logic        m_ready, m_valid, m_busy;
    logic [31:0] m_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model [2][256];

    always #5 clk = ~clk;

    assign v4      = req_valid & ~sel1;
    assign v1      = req_valid & sel1;
    assign m_ready = sel1 ? ready1 : ready4;
    assign m_valid = sel1 ? valid1 : valid4;
    assign m_busy  = sel1 ? busy1  : busy4;
    assign m_data  = sel1 ? data1  : data4;

    mem_controller #(.WORDS(256), .LATENCY(4)) dut (
        .clock(clk), .reset(reset),
        .req_valid(v4), .req_ready(ready4), .req_write(req_write),
        .req_address(req_address), .req_data(req_data), .req_strobe(req_strobe),
        .resp_valid(valid4), .resp_ready(resp_ready), .resp_data(data4), .busy(busy4)
    );

    mem_controller #(.WORDS(256), .LATENCY(1)) dut1 (
        .clock(clk), .reset(reset),
        .req_valid(v1), .req_ready(ready1), .req_write(req_write),
        .req_address(req_address), .req_data(req_data), .req_strobe(req_strobe),
        .resp_valid(valid1), .resp_ready(resp_ready), .resp_data(data1), .busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // One transaction on the selected instance; hold>0 keeps resp_ready low that many cycles.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold);
        logic [31:0] exp;
        int          idx, lat, n, want_lat;
        idx      = int'(addr[9:2]);
        want_lat = sel1 ? 1 : 4;
        if (wr) begin
            exp = bmerge(model[sel1][idx], data, strb);
            model[sel1][idx] = exp;
        end else begin
            exp = model[sel1][idx];
        end
        exp_q.push_back(exp);
        @(negedge clk);
        resp_ready  = (hold == 0);
        req_valid   = 1'b1;
        req_write   = wr;
        req_address = addr;
        req_data    = data;
        req_strobe  = strb;
        for (n = 0; n < 20 && !m_ready; n++) @(negedge clk);
        check_eq("accept_ready", m_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_write   = 1'($urandom);
        req_address = $urandom;
        req_data    = $urandom;
        req_strobe  = 4'($urandom);
        check_eq("ready_drop", m_ready, 1'b0);
        check_eq("busy_high", m_busy, 1'b1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!m_valid && lat < 20);
        check_eq("latency", lat, want_lat);
        exp = exp_q.pop_front();
        check_eq("resp_data", m_data, exp);
        $display("TXN dut=L%0d wr=%0d addr=%h data=%h strb=%h resp=%h exp=%h lat=%0d",
                 want_lat, wr, addr, data, strb, m_data, exp, lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("bp_valid", m_valid, 1'b1);
            check_eq("bp_data", m_data, exp);
            check_eq("bp_ready", m_ready, 1'b0);
            if (i == 1) begin
                req_valid = 1'b1; req_write = 1'b1; req_address = addr;
                req_data = 32'hFFFF_FFFF; req_strobe = 4'hF;
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("resp_done_valid", m_valid, 1'b0);
        check_eq("resp_done_ready", m_ready, 1'b1);
        check_eq("resp_done_busy", m_busy, 1'b0);
    endtask

    initial begin
        logic [31:0] w1, w2, a;
        logic [3:0]  s;
        int          k, got, last;

        sel1 = 1'b0; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b1;
        req_address = '0; req_data = '0; req_strobe = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_valid", valid4, 1'b0);
        check_eq("rst_busy", busy4, 1'b0);
        check_eq("rst_ready", ready4, 1'b1);
        check_eq("rst_data", data4, 32'h0);
        check_eq("rst_data_l1", data1, 32'h0);

        issue(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        issue(0, 32'h10, 32'h0, 4'h0, 0);
        issue(1, 32'h10, 32'h0000_00AA, 4'b0001, 0);
        issue(0, 32'h10, 32'h0, 4'h0, 0);
        issue(1, 32'h10, 32'h1234_5678, 4'b0000, 0);
        issue(0, 32'h10, 32'h0, 4'h0, 0);
        check_eq("partial_model", model[0][4], 32'hDEAD_BEAA);

        issue(1, 32'h400, 32'h1234_5678, 4'hF, 0);
        issue(0, 32'h000, 32'h0, 4'h0, 0);
        issue(0, 32'h403, 32'h0, 4'h0, 0);

        issue(0, 32'h10, 32'h0, 4'h0, 5);
        issue(0, 32'h10, 32'h0, 4'h0, 0);

        for (int r = 0; r < 3; r++) begin
            a  = 32'($urandom_range(64, 127)) << 2;
            w1 = $urandom;
            w2 = $urandom;
            s  = 4'($urandom_range(0, 15));
            issue(1, a, w1, 4'hF, 0);
            issue(1, a, w2, s, 0);
            issue(0, a, 32'h0, 4'h0, 0);
        end

        // Reset two edges after accepting a write must drop it.
        issue(1, 32'h20, 32'h0, 4'hF, 0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_address = 32'h20;
        req_data = 32'h5555_5555; req_strobe = 4'hF;
        check_eq("midrst_ready", ready4, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        $display("TXN dut=L4 wr=1 addr=00000020 data=55555555 strb=f (reset before commit)");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_valid", valid4, 1'b0);
        check_eq("midrst_busy", busy4, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("midrst_quiet", valid4, 1'b0);
        end
        issue(0, 32'h20, 32'h0, 4'h0, 0);

        // LATENCY=1 instance.
        sel1 = 1'b1;
        for (int i = 0; i < 4; i++) issue(1, 32'(i * 4), $urandom, 4'hF, 0);
        issue(0, 32'h4, 32'h0, 4'h0, 0);

        k = 0; got = 0; last = -1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; resp_ready = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (k >= 4) req_valid = 1'b0;
            if (m_valid) begin
                w1 = exp_q.pop_front();
                check_eq("b2b_data", m_data, w1);
                $display("TXN dut=L1 b2b read resp=%h exp=%h", m_data, w1);
                got++;
            end
            if (m_ready && k < 4) begin
                if (last >= 0) check_eq("b2b_gap", c - last, 3);
                last = c;
                req_address = 32'(k * 4);
                exp_q.push_back(model[1][k]);
                k++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check_eq("b2b_count", got, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
